// File: rtl/sdram_defs.sv
// Shared definitions for the two-port SDRAM arbiter: state encoding, arbitration modes, transaction record.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package sdram_defs;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;

  // Values of the arbiter's PRIORITY_MODE parameter
  localparam int PRIO_RR    = 0;  // round-robin between the two ports
  localparam int PRIO_FIXED = 1;  // port 0 always wins contention

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Transaction captured from the winning port at grant time
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xact_t;

endpackage

// File: rtl/sdram_rr_arbiter.sv
// Two-way winner selection: one-hot grant from two requests and a preferred-port pointer.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
module sdram_rr_arbiter (
  input  logic [1:0] req,
  input  logic       rr_ptr,  // port that wins when both request
  output logic [1:0] gnt
);

  // A lone requester wins outright; contention is settled by the pointer
  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = rr_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/sdram_arbiter_module.sv
// Arbitrates two request/done client ports onto one SDRAM controller enable interface.
// Latency: enable 1 cycle after a sampled Req; Done 1 cycle after controller Done; 2 idle cycles between enables.
// Backpressure: ports hold Req until their Done; no grant while the controller reports busy.
module sdram_arbiter_module
  import sdram_defs::*;
#(
  parameter int PRIORITY_MODE = PRIO_RR
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              P0_Req_Sig,
  input  logic              P1_Req_Sig,
  input  logic              P0_Wr_Sig,
  input  logic              P1_Wr_Sig,
  input  logic [ADDR_W-1:0] P0_Addr,
  input  logic [ADDR_W-1:0] P1_Addr,
  input  logic [DATA_W-1:0] P0_WrData,
  input  logic [DATA_W-1:0] P1_WrData,
  output logic              P0_Done_Sig,
  output logic              P1_Done_Sig,
  output logic [DATA_W-1:0] P0_RdData,
  output logic [DATA_W-1:0] P1_RdData,
  output logic [1:0]        Grant_Sig,
  output logic              SD_WrEN_Sig,
  output logic              SD_RdEN_Sig,
  input  logic              SD_Done_Sig,
  input  logic              SD_Busy_Sig,
  output logic [ADDR_W-1:0] SD_Addr,
  output logic [DATA_W-1:0] SD_WrData,
  input  logic [DATA_W-1:0] SD_RdData
);

  state_t      state;
  state_t      state_nxt;
  logic        take;       // accept a new transaction this cycle
  logic        finish;     // controller completed the active transaction
  logic        rr_last;    // port preferred at the next contention
  logic        arb_ptr;
  logic [1:0]  arb_gnt;
  xact_t       cand;
  xact_t       xact;

  // Fixed mode pins the preference on port 0; round-robin uses the completion-updated pointer
  assign arb_ptr = (PRIORITY_MODE == PRIO_FIXED) ? 1'b0 : rr_last;

  sdram_rr_arbiter u_arb (
    .req    ({P1_Req_Sig, P0_Req_Sig}),
    .rr_ptr (arb_ptr),
    .gnt    (arb_gnt)
  );

  // Pick the winner's transaction fields for latching
  always_comb begin
    cand = '0;
    if (arb_gnt[1]) begin
      cand = {P1_Wr_Sig, P1_Addr, P1_WrData};
    end else begin
      cand = {P0_Wr_Sig, P0_Addr, P0_WrData};
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and transaction control decode
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((P0_Req_Sig || P1_Req_Sig) && !SD_Busy_Sig) begin
          take      = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (SD_Done_Sig) begin
          finish    = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
      // One dead cycle lets a finished port drop Req before IDLE samples it again
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Latched transaction, registered enables/grant, Done pulses and read-data capture
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      xact        <= '0;
      Grant_Sig   <= 2'b00;
      SD_WrEN_Sig <= 1'b0;
      SD_RdEN_Sig <= 1'b0;
      P0_Done_Sig <= 1'b0;
      P1_Done_Sig <= 1'b0;
      P0_RdData   <= '0;
      P1_RdData   <= '0;
      rr_last     <= 1'b0;
    end else begin
      P0_Done_Sig <= 1'b0;
      P1_Done_Sig <= 1'b0;
      if (take) begin
        xact        <= cand;
        Grant_Sig   <= arb_gnt;
        SD_WrEN_Sig <= cand.wr;
        SD_RdEN_Sig <= !cand.wr;
      end
      if (finish) begin
        Grant_Sig   <= 2'b00;
        SD_WrEN_Sig <= 1'b0;
        SD_RdEN_Sig <= 1'b0;
        P0_Done_Sig <= Grant_Sig[0];
        P1_Done_Sig <= Grant_Sig[1];
        // The port just served loses the next contention
        rr_last     <= Grant_Sig[0];
        if (!xact.wr) begin
          if (Grant_Sig[0]) P0_RdData <= SD_RdData;
          if (Grant_Sig[1]) P1_RdData <= SD_RdData;
        end
      end
    end
  end

  assign SD_Addr   = xact.addr;
  assign SD_WrData = xact.wdata;

endmodule

// File: tb/tb_sdram_arbiter_module.sv
// Self-checking bench: round-robin DUT plus a fixed-priority DUT driven in lockstep.
// Latency: n/a.
// Backpressure: n/a.
module tb_sdram_arbiter_module;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        P0_Req_Sig, P1_Req_Sig, P0_Wr_Sig, P1_Wr_Sig;
  logic [21:0] P0_Addr, P1_Addr;
  logic [15:0] P0_WrData, P1_WrData;
  logic        P0_Done_Sig, P1_Done_Sig;
  logic [15:0] P0_RdData, P1_RdData;
  logic [1:0]  Grant_Sig;
  logic        SD_WrEN_Sig, SD_RdEN_Sig, SD_Done_Sig, SD_Busy_Sig;
  logic [21:0] SD_Addr;
  logic [15:0] SD_WrData, SD_RdData;

  logic        f_p0_done, f_p1_done, f_wr_en, f_rd_en;
  logic [15:0] f_p0_rd, f_p1_rd, f_wdata;
  logic [1:0]  f_grant;
  logic [21:0] f_addr;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        timeout;
    logic [7:0]  wait_cyc;
    logic [1:0]  gnt;
    logic [1:0]  fgnt;
    logic        wr_en;
    logic        rd_en;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic        stable;
    logic [7:0]  en_cyc;
    logic        en_after;
    logic [1:0]  gnt_rel;
    logic [1:0]  done;
    logic [1:0]  done_after;
    logic [15:0] rd0;
    logic [15:0] rd1;
  } obs_t;

  typedef struct packed {
    logic [1:0]  gnt;
    logic        wr;
    logic [21:0] addr;
    logic [15:0] wdata;
  } exp_t;

  exp_t sb[$];

  sdram_arbiter_module #(.PRIORITY_MODE(0)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .P0_Req_Sig(P0_Req_Sig), .P1_Req_Sig(P1_Req_Sig),
    .P0_Wr_Sig(P0_Wr_Sig), .P1_Wr_Sig(P1_Wr_Sig),
    .P0_Addr(P0_Addr), .P1_Addr(P1_Addr),
    .P0_WrData(P0_WrData), .P1_WrData(P1_WrData),
    .P0_Done_Sig(P0_Done_Sig), .P1_Done_Sig(P1_Done_Sig),
    .P0_RdData(P0_RdData), .P1_RdData(P1_RdData),
    .Grant_Sig(Grant_Sig),
    .SD_WrEN_Sig(SD_WrEN_Sig), .SD_RdEN_Sig(SD_RdEN_Sig),
    .SD_Done_Sig(SD_Done_Sig), .SD_Busy_Sig(SD_Busy_Sig),
    .SD_Addr(SD_Addr), .SD_WrData(SD_WrData), .SD_RdData(SD_RdData)
  );

  sdram_arbiter_module #(.PRIORITY_MODE(1)) dut_fixed (
    .CLK(CLK), .RSTn(RSTn),
    .P0_Req_Sig(P0_Req_Sig), .P1_Req_Sig(P1_Req_Sig),
    .P0_Wr_Sig(P0_Wr_Sig), .P1_Wr_Sig(P1_Wr_Sig),
    .P0_Addr(P0_Addr), .P1_Addr(P1_Addr),
    .P0_WrData(P0_WrData), .P1_WrData(P1_WrData),
    .P0_Done_Sig(f_p0_done), .P1_Done_Sig(f_p1_done),
    .P0_RdData(f_p0_rd), .P1_RdData(f_p1_rd),
    .Grant_Sig(f_grant),
    .SD_WrEN_Sig(f_wr_en), .SD_RdEN_Sig(f_rd_en),
    .SD_Done_Sig(SD_Done_Sig), .SD_Busy_Sig(SD_Busy_Sig),
    .SD_Addr(f_addr), .SD_WrData(f_wdata), .SD_RdData(SD_RdData)
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // The two ports must never see Done together
  always @(negedge CLK) begin
    if (RSTn === 1'b1 && P0_Done_Sig === 1'b1 && P1_Done_Sig === 1'b1) begin
      tests++; fails++;
      $display("FAIL done_exclusive got both Done high at %0t want at most one", $time);
    end
  end

  task automatic idle_inputs();
    P0_Req_Sig = 0; P1_Req_Sig = 0; P0_Wr_Sig = 0; P1_Wr_Sig = 0;
    P0_Addr = '0; P1_Addr = '0; P0_WrData = '0; P1_WrData = '0;
    SD_Done_Sig = 0; SD_Busy_Sig = 0; SD_RdData = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RSTn = 0;
    repeat (2) @(posedge CLK);
    #1 RSTn = 1;
    @(posedge CLK); #1;
  endtask

  // Acts as the SDRAM controller for one transaction and records what the DUT did
  task automatic serve(input int lat, input logic [15:0] rd, output obs_t o);
    int n;
    o = '0;
    n = 0;
    while (!(SD_WrEN_Sig || SD_RdEN_Sig) && n < 60) begin
      @(posedge CLK); #1; n++;
    end
    o.wait_cyc = 8'(n);
    if (n >= 60) begin
      o.timeout = 1;
      return;
    end
    o.gnt = Grant_Sig; o.fgnt = f_grant;
    o.wr_en = SD_WrEN_Sig; o.rd_en = SD_RdEN_Sig;
    o.addr = SD_Addr; o.wdata = SD_WrData;
    o.stable = 1;
    for (int i = 1; i <= lat; i++) begin
      if (!(SD_WrEN_Sig ^ SD_RdEN_Sig) || SD_Addr !== o.addr || SD_WrData !== o.wdata || Grant_Sig !== o.gnt)
        o.stable = 0;
      o.en_cyc++;
      if (i == lat) begin
        SD_Done_Sig = 1; SD_RdData = rd;
      end
      @(posedge CLK); #1;
    end
    SD_Done_Sig = 0;
    o.en_after = SD_WrEN_Sig | SD_RdEN_Sig;
    o.gnt_rel = Grant_Sig;
    o.done = {P1_Done_Sig, P0_Done_Sig};
    o.rd0 = P0_RdData; o.rd1 = P1_RdData;
    @(posedge CLK); #1;
    o.done_after = {P1_Done_Sig, P0_Done_Sig};
  endtask

  task automatic test_reset();
    idle_inputs();
    RSTn = 0;
    @(posedge CLK); #1;
    tests++;
    if (Grant_Sig !== 2'b00 || SD_WrEN_Sig !== 1'b0 || SD_RdEN_Sig !== 1'b0) begin
      fails++; $display("FAIL reset_ctrl got gnt=%b wr=%b rd=%b want 00 0 0", Grant_Sig, SD_WrEN_Sig, SD_RdEN_Sig);
    end
    tests++;
    if (P0_Done_Sig !== 1'b0 || P1_Done_Sig !== 1'b0 || P0_RdData !== 16'h0 || P1_RdData !== 16'h0) begin
      fails++; $display("FAIL reset_port got done=%b%b rd0=%h rd1=%h want 00 0000 0000", P1_Done_Sig, P0_Done_Sig, P0_RdData, P1_RdData);
    end
    tests++;
    if (SD_Addr !== 22'h0 || SD_WrData !== 16'h0) begin
      fails++; $display("FAIL reset_latch got addr=%h wd=%h want 0 0", SD_Addr, SD_WrData);
    end
    #1 RSTn = 1;
    @(posedge CLK); #1;
  endtask

  task automatic test_write();
    obs_t o;
    exp_t e;
    do_reset();
    P0_Req_Sig = 1; P0_Wr_Sig = 1; P0_Addr = 22'h000123; P0_WrData = 16'hA5A5;
    sb.push_back('{gnt: 2'b01, wr: 1'b1, addr: 22'h000123, wdata: 16'hA5A5});
    serve(5, 16'hDEAD, o);
    P0_Req_Sig = 0;
    e = sb.pop_front();
    tests++;
    if (o.timeout || o.gnt !== e.gnt || o.wr_en !== e.wr || o.rd_en !== ~e.wr || o.addr !== e.addr || o.wdata !== e.wdata) begin
      fails++; $display("FAIL write_xact got to=%b gnt=%b wr=%b rd=%b addr=%h wd=%h want gnt=%b wr=%b addr=%h wd=%h",
                        o.timeout, o.gnt, o.wr_en, o.rd_en, o.addr, o.wdata, e.gnt, e.wr, e.addr, e.wdata);
    end
    tests++;
    if (o.wait_cyc !== 8'd1) begin
      fails++; $display("FAIL write_latency got %0d want 1", o.wait_cyc);
    end
    tests++;
    if (o.stable !== 1'b1 || o.en_cyc !== 8'd5 || o.en_after !== 1'b0) begin
      fails++; $display("FAIL write_enable got stable=%b cycles=%0d after=%b want 1 5 0", o.stable, o.en_cyc, o.en_after);
    end
    tests++;
    if (o.done !== 2'b01 || o.done_after !== 2'b00 || o.gnt_rel !== 2'b00) begin
      fails++; $display("FAIL write_done got done=%b next=%b relgnt=%b want 01 00 00", o.done, o.done_after, o.gnt_rel);
    end
    tests++;
    if (o.rd0 !== 16'h0000) begin
      fails++; $display("FAIL write_no_capture got rd0=%h want 0000", o.rd0);
    end
  endtask

  task automatic test_contention();
    obs_t o;
    exp_t e;
    do_reset();
    P0_Req_Sig = 1; P0_Wr_Sig = 0; P0_Addr = 22'h010000;
    P1_Req_Sig = 1; P1_Wr_Sig = 0; P1_Addr = 22'h020000;
    sb.push_back('{gnt: 2'b01, wr: 1'b0, addr: 22'h010000, wdata: 16'h0});
    sb.push_back('{gnt: 2'b10, wr: 1'b0, addr: 22'h020000, wdata: 16'h0});
    serve(3, 16'h1111, o);
    P0_Req_Sig = 0;
    e = sb.pop_front();
    tests++;
    if (o.timeout || o.gnt !== e.gnt || o.rd_en !== ~e.wr || o.addr !== e.addr) begin
      fails++; $display("FAIL contend_first got gnt=%b rd=%b addr=%h want gnt=%b rd=1 addr=%h", o.gnt, o.rd_en, o.addr, e.gnt, e.addr);
    end
    tests++;
    if (o.done !== 2'b01 || o.rd0 !== 16'h1111) begin
      fails++; $display("FAIL contend_first_data got done=%b rd0=%h want 01 1111", o.done, o.rd0);
    end
    serve(2, 16'h5A5A, o);
    P1_Req_Sig = 0;
    e = sb.pop_front();
    tests++;
    if (o.timeout || o.gnt !== e.gnt || o.rd_en !== ~e.wr || o.addr !== e.addr || o.wait_cyc !== 8'd1) begin
      fails++; $display("FAIL contend_second got gnt=%b rd=%b addr=%h wait=%0d want gnt=%b rd=1 addr=%h wait=1",
                        o.gnt, o.rd_en, o.addr, o.wait_cyc, e.gnt, e.addr);
    end
    tests++;
    if (o.done !== 2'b10 || o.rd1 !== 16'h5A5A || o.rd0 !== 16'h1111) begin
      fails++; $display("FAIL contend_second_data got done=%b rd1=%h rd0=%h want 10 5a5a 1111", o.done, o.rd1, o.rd0);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    do_reset();
    P0_Req_Sig = 1; P0_Wr_Sig = 1; P0_Addr = 22'h000AAA; P0_WrData = 16'h0A0A;
    P1_Req_Sig = 1; P1_Wr_Sig = 1; P1_Addr = 22'h000BBB; P1_WrData = 16'h0B0B;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) sb.push_back('{gnt: 2'b01, wr: 1'b1, addr: 22'h000AAA, wdata: 16'h0A0A});
      else            sb.push_back('{gnt: 2'b10, wr: 1'b1, addr: 22'h000BBB, wdata: 16'h0B0B});
    end
    for (int k = 0; k < 4; k++) begin
      serve(2 + k, 16'h0, o);
      e = sb.pop_front();
      tests++;
      if (o.timeout || o.gnt !== e.gnt || o.addr !== e.addr || o.wdata !== e.wdata || o.wr_en !== e.wr) begin
        fails++; $display("FAIL rr_xact%0d got gnt=%b addr=%h wd=%h want gnt=%b addr=%h wd=%h", k, o.gnt, o.addr, o.wdata, e.gnt, e.addr, e.wdata);
      end
      tests++;
      if (o.fgnt !== 2'b01) begin
        fails++; $display("FAIL fixed_grant%0d got %b want 01", k, o.fgnt);
      end
      tests++;
      if (k > 0 && o.wait_cyc !== 8'd1) begin
        fails++; $display("FAIL rr_spacing%0d got wait=%0d want 1", k, o.wait_cyc);
      end
    end
    P0_Req_Sig = 0; P1_Req_Sig = 0;
  endtask

  task automatic test_busy();
    obs_t o;
    int bad;
    do_reset();
    SD_Busy_Sig = 1;
    P1_Req_Sig = 1; P1_Wr_Sig = 0; P1_Addr = 22'h3F0001;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (SD_WrEN_Sig || SD_RdEN_Sig || Grant_Sig != 2'b00) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL busy_hold got %0d granted cycles want 0", bad);
    end
    SD_Busy_Sig = 0;
    serve(2, 16'hC3C3, o);
    P1_Req_Sig = 0;
    tests++;
    if (o.timeout || o.wait_cyc !== 8'd1 || o.rd_en !== 1'b1 || o.gnt !== 2'b10) begin
      fails++; $display("FAIL busy_release got wait=%0d rd=%b gnt=%b want 1 1 10", o.wait_cyc, o.rd_en, o.gnt);
    end
    tests++;
    if (o.rd1 !== 16'hC3C3 || o.done !== 2'b10) begin
      fails++; $display("FAIL busy_data got rd1=%h done=%b want c3c3 10", o.rd1, o.done);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int n;
    int dc;
    do_reset();
    P0_Req_Sig = 1; P0_Wr_Sig = 1; P0_Addr = 22'h3ABCDE; P0_WrData = 16'h1234;
    n = 0;
    while (!SD_WrEN_Sig && n < 20) begin
      @(posedge CLK); #1; n++;
    end
    tests++;
    if (n != 1) begin
      fails++; $display("FAIL midrst_issue got wait=%0d want 1", n);
    end
    @(posedge CLK); #3;
    RSTn = 0;
    #1;
    tests++;
    if (SD_WrEN_Sig !== 1'b0 || SD_RdEN_Sig !== 1'b0 || Grant_Sig !== 2'b00) begin
      fails++; $display("FAIL midrst_drop got wr=%b rd=%b gnt=%b want 0 0 00", SD_WrEN_Sig, SD_RdEN_Sig, Grant_Sig);
    end
    P0_Req_Sig = 0;
    dc = 0;
    for (int i = 0; i < 4; i++) begin
      SD_Done_Sig = (i == 1);
      @(posedge CLK); #1;
      dc += int'(P0_Done_Sig) + int'(P1_Done_Sig);
    end
    SD_Done_Sig = 0;
    RSTn = 1;
    @(posedge CLK); #1;
    dc += int'(P0_Done_Sig) + int'(P1_Done_Sig);
    tests++;
    if (dc != 0) begin
      fails++; $display("FAIL midrst_no_done got %0d pulses want 0", dc);
    end
    P1_Req_Sig = 1; P1_Wr_Sig = 0; P1_Addr = 22'h000777;
    serve(2, 16'h7777, o);
    P1_Req_Sig = 0;
    tests++;
    if (o.timeout || o.wait_cyc !== 8'd1 || o.gnt !== 2'b10 || o.done !== 2'b10 || o.rd1 !== 16'h7777) begin
      fails++; $display("FAIL midrst_next got wait=%0d gnt=%b done=%b rd1=%h want 1 10 10 7777", o.wait_cyc, o.gnt, o.done, o.rd1);
    end
  endtask

  task automatic test_spurious();
    int dc;
    int en;
    @(posedge CLK); #1;
    SD_Done_Sig = 1; SD_RdData = 16'hBEEF;
    dc = 0; en = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      SD_Done_Sig = 0;
      dc += int'(P0_Done_Sig) + int'(P1_Done_Sig);
      en += int'(SD_WrEN_Sig) + int'(SD_RdEN_Sig);
    end
    tests++;
    if (dc != 0 || en != 0) begin
      fails++; $display("FAIL spurious_done got done=%0d en=%0d want 0 0", dc, en);
    end
    tests++;
    if (P0_RdData !== 16'h0000 || P1_RdData !== 16'h7777) begin
      fails++; $display("FAIL spurious_data got rd0=%h rd1=%h want 0000 7777", P0_RdData, P1_RdData);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_contention();
    test_back_to_back();
    test_busy();
    test_reset_mid();
    test_spurious();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter_module.md
SDRAM_ARBITER_MODULE -- requirements
Module: sdram_arbiter_module

Interface
REQ-001 SHALL have parameter PRIORITY_MODE, default 0, meaning 0 = round-robin and 1 = fixed priority with port 0 always winning.
REQ-002 SHALL have port CLK  input  1  system clock; all logic rising-edge.
REQ-003 SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports P0_Req_Sig / P1_Req_Sig  input  1 each  access request, level, held until the port's Done.
REQ-005 SHALL have ports P0_Wr_Sig / P1_Wr_Sig  input  1 each  1 = write, 0 = read; sampled with Req.
REQ-006 SHALL have ports P0_Addr / P1_Addr  input  22 each  bank/row/column address.
REQ-007 SHALL have ports P0_WrData / P1_WrData  input  16 each  write data.
REQ-008 SHALL have ports P0_Done_Sig / P1_Done_Sig  output  1 each  one-cycle completion pulse.
REQ-009 SHALL have ports P0_RdData / P1_RdData  output  16 each  read data, held until that port's next read completes.
REQ-010 SHALL have port Grant_Sig  output  2  one-hot owner of the current transaction; 2'b00 when idle.
REQ-011 SHALL have ports SD_WrEN_Sig / SD_RdEN_Sig  output  1 each  level enables to the SDRAM controller.
REQ-012 SHALL have ports SD_Done_Sig / SD_Busy_Sig  input  1 each  controller completion pulse / busy (refresh or init in progress).
REQ-013 SHALL have ports SD_Addr (22), SD_WrData (16) as outputs, SD_RdData (16) as input: controller address/data.

Function
REQ-014 SHALL implement states IDLE, ISSUE and RELEASE.
REQ-015 In IDLE, when at least one Req is high and SD_Busy_Sig is low, SHALL select a winner, latch its Wr/Addr/WrData into internal registers, set Grant_Sig and go to ISSUE on the next edge.
REQ-016 While SD_Busy_Sig is high in IDLE, SHALL not grant.
REQ-017 Round-robin (PRIORITY_MODE=0): on simultaneous requests SHALL grant the port that was not served most recently; the pointer updates only on transaction completion.
REQ-018 In ISSUE, SHALL hold exactly one of SD_WrEN_Sig/SD_RdEN_Sig high, selected by the latched Wr, with SD_Addr/SD_WrData driven from the latched registers and constant throughout ISSUE.
REQ-019 In ISSUE, on a cycle with SD_Done_Sig high, SHALL drop both enables on the next edge, capture SD_RdData into the winner's RdData register (reads only), pulse the winner's Done for exactly that one cycle, and enter RELEASE.
REQ-020 RELEASE SHALL last one cycle with Grant_Sig = 0, then return to IDLE, so a port that drops Req after Done is never re-granted.
REQ-021 Request-to-enable latency SHALL be 1 cycle from a sampled Req in IDLE; minimum spacing between consecutive enables SHALL be 2 cycles.
REQ-022 A Req dropped or changed during ISSUE SHALL be ignored: the latched transaction completes and Done still pulses.
REQ-023 An SD_Done_Sig seen outside ISSUE SHALL be ignored; no Done pulse or data capture occurs.
REQ-024 P0_Done_Sig and P1_Done_Sig SHALL never be high in the same cycle.

Reset
REQ-025 On RSTn low, SHALL asynchronously set state to IDLE, all enables, Done, Grant and data outputs to 0, latched registers to 0, and the round-robin pointer so that port 0 wins the first contention.
REQ-026 A reset asserted mid-ISSUE SHALL abandon the transaction with no Done pulse.

Structure
REQ-027 State encodings and the PRIORITY_MODE values SHALL live in a shared sdram_defs package.
REQ-028 The winner-selection logic SHALL be one sub-module, sdram_rr_arbiter: inputs 2 requests and the pointer, output a one-hot grant.

Verification
REQ-029 P0 write, Addr=22'h000123, WrData=16'hA5A5, controller Done 5 cycles later -> SD_WrEN high 1 cycle after Req, for 5 cycles; P0_Done one pulse; Grant=01.
REQ-030 P0 and P1 request reads in the same cycle after reset -> P0 served first, then P1; P1_RdData = SD_RdData value 16'h5A5A.
REQ-031 Both ports request continuously for 4 transactions -> grants alternate 01,10,01,10 in round-robin mode; in fixed mode P0 wins every time.
REQ-032 SD_Busy_Sig high for 20 cycles while P1 requests -> no enable until Busy falls, then SD_RdEN asserts 1 cycle later.
REQ-033 RSTn pulsed low mid-ISSUE -> enables drop immediately; no Done pulse; the next request is granted normally.
REQ-034 Spurious SD_Done_Sig in IDLE -> no Done pulse on either port; RdData registers unchanged.
